// File: rtl/ddr_pkg.sv
// ddr_pkg: shared widths, command-bit positions, FSM state encoding and the
// queued request record for the ddr_sdram request queue.
package ddr_pkg;

  localparam int BA_W    = 2;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 2;
  localparam int ENTRY_W = 1 + BA_W + ADDR_W + DATA_W + LEN_W;  // 44

  // COMMAND bit positions towards ddr_sdram
  localparam int CMD_RW  = 1;  // 1 = write, 0 = read
  localparam int CMD_REQ = 0;  // action requested

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Field order fixes the 44-bit packing {write, ba, addr, data, len}
  typedef struct packed {
    logic              write;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } entry_t;

endpackage

// File: rtl/ddr_sync_fifo.sv
// ddr_sync_fifo: synchronous FIFO with head peek.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data at tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : entry at the read pointer, valid whenever count != 0
//   count      : entries held, 0..DEPTH
module ddr_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count_q != FULL);
  assign pop_ok  = pop && (count_q != '0);

  // Pointers are PW bits wide, so the increment wraps modulo DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ddr_cmd_queue.sv
// ddr_cmd_queue: request buffer in front of ddr_sdram. Requests are queued
// and presented one at a time on ddr_sdram's master interface; each is
// retired on a rising edge of ACCEPTED or dropped (ERR set) on timeout.
//   DDR_CLK, RESET_N       : clock, asynchronous active-low reset
//   REQ_*                  : request input (valid/ready), fields stored as-is
//   BA_IN..WRITE_LENGTH    : request presented to ddr_sdram
//   COMMAND                : [1] write/read, [0] action requested
//   ACCEPTED               : from ddr_sdram, rising edge = task complete
//   COUNT                  : entries held, including the one in flight
//   BUSY                   : FSM not idle
//   ERR / ERR_CLR          : sticky timeout flag and its synchronous clear
//
// Handshake: a request transfers on a clock edge where REQ_VALID and
// REQ_READY are both high. REQ_READY depends only on the registered COUNT,
// so a retire in the same cycle does not open a slot until the next cycle.
module ddr_cmd_queue
  import ddr_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    DDR_CLK,
  input  logic                    RESET_N,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WRITE,
  input  logic [1:0]              REQ_BA,
  input  logic [22:0]             REQ_ADDR,
  input  logic [15:0]             REQ_DATA,
  input  logic [1:0]              REQ_LEN,
  output logic [1:0]              BA_IN,
  output logic [22:0]             ADDR_IN,
  output logic [15:0]             DATA_IN,
  output logic [1:0]              COMMAND,
  output logic [1:0]              WRITE_LENGTH,
  input  logic                    ACCEPTED,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    BUSY,
  output logic                    ERR,
  input  logic                    ERR_CLR
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL         = CW'(DEPTH);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [7:0]        timer_q, timer_d;
  logic              err_q, err_d;
  logic              acc_q;
  logic              rise;
  logic              push, pop;
  logic [CW-1:0]     fifo_count;
  logic [ENTRY_W-1:0] head_bits;
  entry_t            head;
  entry_t            wr_entry;

  assign REQ_READY = (fifo_count != FULL);
  assign push      = REQ_VALID && REQ_READY;
  assign wr_entry  = '{write: REQ_WRITE, ba: REQ_BA, addr: REQ_ADDR,
                       data: REQ_DATA, len: REQ_LEN};
  assign head      = entry_t'(head_bits);
  assign rise      = ACCEPTED && !acc_q;

  ddr_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (DDR_CLK),
    .rst_n   (RESET_N),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .head    (head_bits),
    .count   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    ba_d    = ba_q;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    timer_d = timer_q;
    pop     = 1'b0;
    err_d   = err_q && !ERR_CLR;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          ba_d           = head.ba;
          addr_d         = head.addr;
          data_d         = head.data;
          len_d          = head.len;
          cmd_d[CMD_RW]  = head.write;
          cmd_d[CMD_REQ] = 1'b1;
          timer_d        = '0;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = timer_q + 8'd1;
        // An acknowledge in the final timeout cycle still counts as success
        if (rise) begin
          cmd_d   = 2'b00;
          pop     = 1'b1;
          state_d = ST_GAP;
        end else if (timer_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cmd_d   = 2'b00;
          pop     = 1'b1;
          state_d = ST_GAP;
        end
      end
      // One low cycle on COMMAND[0] so ddr_sdram sees a fresh request edge
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge DDR_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ba_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      acc_q   <= ACCEPTED;
    end
  end

  assign BA_IN        = ba_q;
  assign ADDR_IN      = addr_q;
  assign DATA_IN      = data_q;
  assign WRITE_LENGTH = len_q;
  assign COMMAND      = cmd_q;
  assign COUNT        = fifo_count;
  assign BUSY         = (state_q != ST_IDLE);
  assign ERR          = err_q;

endmodule

// File: tb/tb_ddr_cmd_queue.sv
// Bench for ddr_cmd_queue with a short timeout. Stimulus is driven 1ns after
// the rising edge; the monitor samples on the falling edge, compares every
// output against a request-level model, then predicts the next edge.
module tb_ddr_cmd_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        DDR_CLK = 1'b0;
  logic        RESET_N;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [1:0]  REQ_BA, REQ_LEN;
  logic [22:0] REQ_ADDR;
  logic [15:0] REQ_DATA;
  logic [1:0]  BA_IN, COMMAND, WRITE_LENGTH;
  logic [22:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic        ACCEPTED, BUSY, ERR, ERR_CLR;
  logic [2:0]  COUNT;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 DDR_CLK = ~DDR_CLK;

  ddr_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .DDR_CLK      (DDR_CLK),
    .RESET_N      (RESET_N),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_WRITE    (REQ_WRITE),
    .REQ_BA       (REQ_BA),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_DATA     (REQ_DATA),
    .REQ_LEN      (REQ_LEN),
    .BA_IN        (BA_IN),
    .ADDR_IN      (ADDR_IN),
    .DATA_IN      (DATA_IN),
    .COMMAND      (COMMAND),
    .WRITE_LENGTH (WRITE_LENGTH),
    .ACCEPTED     (ACCEPTED),
    .COUNT        (COUNT),
    .BUSY         (BUSY),
    .ERR          (ERR),
    .ERR_CLR      (ERR_CLR)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Entry layout {write[43], ba[42:41], addr[40:18], data[17:2], len[1:0]}
  logic [43:0] exp_q[$];
  logic [43:0] last     = '0;   // request currently/last presented
  bit          m_issued = 0;    // a request is on COMMAND
  bit          m_gap    = 0;    // the mandatory low cycle after a retire
  bit          m_err    = 0;
  bit          acc_prev = 0;
  int          m_n      = 0;    // cycles the current request has been presented

  always @(negedge DDR_CLK) begin : monitor
    bit rise, push, tout;
    if (!RESET_N) begin
      exp_q.delete();
      last = '0; m_issued = 0; m_gap = 0; m_err = 0; acc_prev = 0; m_n = 0;
    end else begin
      chk("command", COMMAND, m_issued ? {last[43], 1'b1} : 2'b00);
      chk("ba_in",   BA_IN,   last[42:41]);
      chk("addr_in", ADDR_IN, last[40:18]);
      chk("data_in", DATA_IN, last[17:2]);
      chk("wr_len",  WRITE_LENGTH, last[1:0]);
      chk("count",   COUNT,   exp_q.size());
      chk("req_ready", REQ_READY, exp_q.size() != DEPTH);
      chk("busy",    BUSY,    m_issued || m_gap);
      chk("err",     ERR,     m_err);
      // predict the coming edge
      rise = ACCEPTED && !acc_prev;
      acc_prev = ACCEPTED;
      push = REQ_VALID && (exp_q.size() != DEPTH);
      tout = 0;
      if (m_issued) begin
        m_n++;
        if (rise || m_n == TIMEOUT) begin
          tout = !rise;
          void'(exp_q.pop_front());
          m_issued = 0;
          m_gap = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (exp_q.size() != 0) begin
        m_issued = 1;
        m_n = 0;
        last = exp_q[0];
      end
      m_err = tout || (m_err && !ERR_CLR);
      if (push) exp_q.push_back({REQ_WRITE, REQ_BA, REQ_ADDR, REQ_DATA, REQ_LEN});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic w, input logic [1:0] ba,
                     input logic [22:0] addr, input logic [15:0] data,
                     input logic [1:0] len, input logic acc, input logic clr);
    @(posedge DDR_CLK); #1;
    REQ_VALID = v; REQ_WRITE = w; REQ_BA = ba; REQ_ADDR = addr;
    REQ_DATA = data; REQ_LEN = len; ACCEPTED = acc; ERR_CLR = clr;
  endtask

  task automatic idle(input int n, input logic acc);
    repeat (n) cyc(1'b0, 1'b0, 2'd0, 23'd0, 16'd0, 2'd0, acc, 1'b0);
  endtask

  task automatic push_rand(input logic v, input logic acc, input logic clr);
    cyc(v, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
        23'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), acc, clr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    RESET_N = 1'b0; REQ_VALID = 0; REQ_WRITE = 0; REQ_BA = 0; REQ_ADDR = 0;
    REQ_DATA = 0; REQ_LEN = 0; ACCEPTED = 0; ERR_CLR = 0;
    repeat (3) @(posedge DDR_CLK);
    #1;
    chk("rst_command", COMMAND, 2'b00);
    chk("rst_count",   COUNT, 3'd0);
    chk("rst_busy",    BUSY, 1'b0);
    chk("rst_err",     ERR, 1'b0);
    chk("rst_ba_addr", {BA_IN, ADDR_IN, DATA_IN, WRITE_LENGTH}, '0);
    RESET_N = 1'b1;

    // single write, acked by one pulse
    cyc(1'b1, 1'b1, 2'd1, 23'h12345, 16'hBEEF, 2'd2, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // fill the queue with ACCEPTED low, hold a fifth valid, retire one
    repeat (6) push_rand(1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    repeat (3) push_rand(1'b1, 1'b0, 1'b0);
    idle(30, 1'b0);

    // back-to-back, each acked three cycles after issue
    repeat (3) push_rand(1'b1, 1'b0, 1'b0);
    repeat (3) begin
      idle(2, 1'b0);
      idle(1, 1'b1);
    end
    idle(6, 1'b0);

    // ACCEPTED held high: one retire only, second request times out
    repeat (2) push_rand(1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(20, 1'b1);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 23'd0, 16'd0, 2'd0, 1'b0, 1'b1);  // clear ERR
    idle(3, 1'b0);

    // random traffic
    for (int i = 0; i < 800; i++)
      push_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 15) == 0));

    // timeouts with no acks, then clear
    idle(4, 1'b0);
    repeat (3) push_rand(1'b1, 1'b0, 1'b0);
    idle(40, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 23'd0, 16'd0, 2'd0, 1'b0, 1'b1);
    idle(3, 1'b0);

    // asynchronous reset while a request is presented and more are queued
    repeat (4) push_rand(1'b1, 1'b0, 1'b0);
    w = 0;
    while (COMMAND[0] !== 1'b1 && w < 20) begin
      idle(1, 1'b0);
      w++;
    end
    chk("wait_issue", COMMAND[0], 1'b1);
    @(posedge DDR_CLK); #3;
    RESET_N = 1'b0;
    #1;
    chk("arst_command", COMMAND, 2'b00);
    chk("arst_count",   COUNT, 3'd0);
    chk("arst_busy",    BUSY, 1'b0);
    repeat (2) @(posedge DDR_CLK);
    #1;
    RESET_N = 1'b1;
    idle(5, 1'b0);
    push_rand(1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
